// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Purpose  : Fills the instruction memory from a byte stream (big-endian
//            16-bit length, then words) and stalls the CPU while loading.
//            Option LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
    parameter int          WORD_LEN    = 16,
    parameter int          ADDRESS_LEN = 16,
    parameter int unsigned MEMORY_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   wr_en,
    output logic [ADDRESS_LEN-1:0] wr_adr,
    output logic [WORD_LEN-1:0]    wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_WRITE   = 4'd5,
`ifdef LOADER_CHECKSUM_EN
        S_CHK     = 4'd8,
`endif
        S_DONE    = 4'd6,
        S_ERR     = 4'd7
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_ready;
    logic                     w_start_ok;
    logic                     w_accept;
    logic [15:0]              w_len;
    logic [ADDRESS_LEN-1:0]   w_cnt_inc;

    logic [7:0]               r_len_hi;
    logic [15:0]              r_len;
    logic [ADDRESS_LEN-1:0]   r_cnt;
    logic [ADDRESS_LEN-1:0]   r_wr_adr;
    logic [WORD_LEN-1:0]      r_wr_data;
    logic                     r_wr_en;
    logic                     r_cpu_hold;
    logic                     r_done;
    logic                     r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               r_csum;
`endif

    assign w_accept  = byte_valid & w_ready;
    assign w_len     = {r_len_hi, byte_in};
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_start_ok = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    w_next     = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                w_ready = 1'b1;
                if (byte_valid) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_ready = 1'b1;
                if (byte_valid) begin
                    if (32'(w_len) > MEMORY_SIZE) w_next = S_ERR;
                    else if (w_len == 16'd0)      w_next = S_DONE;
                    else                          w_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                w_ready = 1'b1;
                if (byte_valid) w_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                w_ready = 1'b1;
                if (byte_valid) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_cnt_inc == ADDRESS_LEN'(r_len)) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end else begin
                    w_next = S_DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                w_ready = 1'b1;
                if (byte_valid) w_next = (byte_in == r_csum) ? S_DONE : S_ERR;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_len_hi   <= 8'd0;
            r_len      <= 16'd0;
            r_cnt      <= '0;
            r_wr_adr   <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_state    <= w_next;
            r_wr_en    <= (w_next == S_WRITE);
            r_cpu_hold <= !((w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_ERR));
            r_done     <= (w_next == S_DONE) && (r_state != S_DONE);
            if (w_start_ok)            r_err <= 1'b0;
            else if (w_next == S_ERR)  r_err <= 1'b1;

            if (w_start_ok) begin
                r_cnt    <= '0;
                r_wr_adr <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum   <= 8'd0;
`endif
            end

            if (w_accept) begin
                case (r_state)
                    S_LEN_HI:  r_len_hi <= byte_in;
                    S_LEN_LO:  r_len    <= w_len;
                    S_DATA_HI: begin
                        r_wr_data[15:8] <= byte_in;
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ byte_in;
`endif
                    end
                    S_DATA_LO: begin
                        r_wr_data[7:0] <= byte_in;
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ byte_in;
`endif
                    end
                    default: ;
                endcase
            end

            if (r_state == S_WRITE) begin
                r_cnt    <= w_cnt_inc;
                r_wr_adr <= r_wr_adr + 1'b1;
            end
        end
    end

    assign byte_ready = w_ready;
    assign wr_en      = r_wr_en;
    assign wr_adr     = r_wr_adr;
    assign wr_data    = r_wr_data;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// Directed bench for inst_mem_loader: scoreboard of expected writes checked on
// the falling edge, plus status checks at each step.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [15:0] wr_adr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];

    inst_mem_loader #(
        .WORD_LEN   (16),
        .ADDRESS_LEN(16),
        .MEMORY_SIZE(256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_adr    (wr_adr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every wr_en cycle must match the oldest expected word.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("wr_word", {wr_adr, wr_data}, exp_q.pop_front());
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (byte_ready === 1'b1) break;
            n++;
            if (n > 40) begin
                chk("ready_timeout", 32'(byte_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        @(posedge clk); #1;
        send(b);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            chk({tag, "_hold_busy"}, 32'(cpu_hold), 32'd1);
        end
        if (!seen) chk({tag, "_done_timeout"}, 32'(done), 32'd1);
        chk({tag, "_hold_at_done"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_err_at_done"}, 32'(err), 32'd0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_adr"}, 32'(wr_adr), 32'd0);
        chk({tag, "_data"}, 32'(wr_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Bytes offered while idle are not consumed
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        @(posedge clk); #1;
        byte_valid = 1'b0;

        // Normal load
        done_cnt = 0;
        exp_q.push_back(32'h0000_C511);
        exp_q.push_back(32'h0001_01F4);
        do_start();
        chk("hold_after_start", 32'(cpu_hold), 32'd1);
        send(8'h00); send(8'h02);
        send(8'hC5); send(8'h11);
        send(8'h01); send(8'hF4);
`ifdef LOADER_CHECKSUM_EN
        send(8'h21);
`endif
        wait_done("normal");
        chk("normal_q_empty", 32'(exp_q.size()), 32'd0);
        chk("normal_done_cnt", 32'(done_cnt), 32'd1);

        // Backpressure with gaps, plus an ignored start mid-load
        done_cnt = 0;
        exp_q.push_back(32'h0000_C511);
        exp_q.push_back(32'h0001_01F4);
        do_start();
        send_gap(8'h00); send_gap(8'h02);
        send_gap(8'hC5);
        do_start();
        chk("busy_start_hold", 32'(cpu_hold), 32'd1);
        send_gap(8'h11);
        send_gap(8'h01); send_gap(8'hF4);
`ifdef LOADER_CHECKSUM_EN
        send_gap(8'h21);
`endif
        wait_done("gap");
        chk("gap_q_empty", 32'(exp_q.size()), 32'd0);
        chk("gap_done_cnt", 32'(done_cnt), 32'd1);

        // Zero length
        done_cnt = 0;
        do_start();
        send(8'h00); send(8'h00);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_err", 32'(err), 32'd0);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        @(negedge clk);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);

        // Oversize length 257
        done_cnt = 0;
        do_start();
        send(8'h01); send(8'h01);
        @(negedge clk);
        chk("over_err", 32'(err), 32'd1);
        chk("over_hold", 32'(cpu_hold), 32'd0);
        chk("over_done", 32'(done), 32'd0);
        chk("over_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        chk("over_err_sticky", 32'(err), 32'd1);
        @(posedge clk); #1;
        do_start();
        chk("over_err_cleared", 32'(err), 32'd0);
        chk("over_done_cnt", 32'(done_cnt), 32'd0);

        // Reset mid-load: 3 words written, then abandon in DATA_LO
        exp_q.push_back(32'h0000_1111);
        exp_q.push_back(32'h0001_2222);
        exp_q.push_back(32'h0002_3333);
        send(8'h00); send(8'h05);
        send(8'h11); send(8'h11);
        send(8'h22); send(8'h22);
        send(8'h33); send(8'h33);
        send(8'hAB);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        chk("midrst_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_ready", 32'(byte_ready), 32'd0);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        // Checksum good then bad
        done_cnt = 0;
        exp_q.push_back(32'h0000_1234);
        do_start();
        send(8'h00); send(8'h01);
        send(8'h12); send(8'h34);
        send(8'h26);
        wait_done("csum_ok");
        exp_q.push_back(32'h0000_1234);
        do_start();
        send(8'h00); send(8'h01);
        send(8'h12); send(8'h34);
        send(8'h27);
        @(negedge clk);
        chk("csum_bad_err", 32'(err), 32'd1);
        chk("csum_bad_done", 32'(done), 32'd0);
        chk("csum_bad_hold", 32'(cpu_hold), 32'd0);
        chk("csum_done_cnt", 32'(done_cnt), 32'd1);
        chk("csum_q_empty", 32'(exp_q.size()), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side counterpart of the pipeline's instruction memory: fills the program store instead of fetching from it.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Drives the instruction memory write port at sequential addresses from 0.
- Holds the CPU in stall (cpu_hold) while a load is in progress.

Parameters:
- WORD_LEN, 16, instruction word width; fixed at 2 bytes.
- ADDRESS_LEN, 16, width of the write address and the word counter.
- MEMORY_SIZE, 256, number of instruction words; largest legal program length.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session; honoured only in IDLE, DONE or ERR.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_adr  output  ADDRESS_LEN  write word address.
- wr_data  output  WORD_LEN  write word.
- cpu_hold  output  1  stall request to the pipeline.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky error flag; cleared by start or reset.

Behaviour:
- Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both 1. byte_in must stay stable while valid is high and ready is low.
- Reset (rst=0, asynchronous) forces the following, all held until the first edge after rst rises:
  - state=IDLE;
  - byte_ready, wr_en, cpu_hold, done, err = 0;
  - wr_adr, wr_data, word counter, length register = 0.
- Reset asserted mid-load abandons the session at once. Words already written stay in memory.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, (CHK), DONE, ERR.
- IDLE / DONE / ERR: byte_ready=0. start -> LEN_HI and clears err, word counter and wr_adr. cpu_hold rises the cycle after start.
- LEN_HI: byte_ready=1. On accept, latch the length high byte -> LEN_LO.
- LEN_LO: byte_ready=1. On accept, form N={hi,lo}:
  - N > MEMORY_SIZE -> ERR; err=1 next cycle.
  - N = 0 -> DONE.
  - otherwise -> DATA_HI.
- DATA_HI: byte_ready=1. On accept, latch wr_data[15:8] -> DATA_LO.
- DATA_LO: byte_ready=1. On accept, latch wr_data[7:0] -> WRITE.
- WRITE: byte_ready=0; wr_en=1 for exactly this one cycle, wr_adr=counter.
  - Next edge: counter+1 and wr_adr+1.
  - If the incremented counter equals N -> DONE (or CHK when LOADER_CHECKSUM_EN is defined); else -> DATA_HI.
- Latency: wr_en is asserted the cycle after the low byte is accepted. Minimum throughput is 3 cycles per word.
- Entry into DONE: done=1 for exactly one cycle and cpu_hold=0 in the same cycle.
- Entry into ERR: cpu_hold=0 and err=1; err stays at 1 until start or reset.
- wr_adr wraps modulo 2^ADDRESS_LEN. The length check guarantees it never exceeds MEMORY_SIZE-1 during a legal load.
- start while a load is active (LEN_HI..CHK) is ignored.
- byte_valid outside the load states is ignored; no byte is consumed.
- err is cleared in the same cycle a new start is accepted.
- cpu_hold is registered and equals 1 in every state from LEN_HI to CHK inclusive.
- wr_en is 0 in every state except WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator is cleared on start and XORs every accepted data byte (length bytes excluded).
  - After the last WRITE, enter CHK with byte_ready=1.
  - Accepted byte equal to the accumulator -> DONE; any other value -> ERR.
- Undefined: no CHK state and no accumulator; the last WRITE goes straight to DONE.

Test Plan:
- Reset mid-load: rst low while in DATA_LO after 3 words written -> all outputs 0 immediately, state IDLE. Bytes offered afterwards get byte_ready=0.
- Normal load: start; bytes 00 02 C5 11 01 F4 -> writes adr0=C511, adr1=01F4, one wr_en cycle each. done pulses once; cpu_hold high from the cycle after start until done.
- Backpressure and gaps: same stream with byte_valid toggled every other cycle -> identical writes and addresses, no byte dropped or duplicated.
- Zero length: start; bytes 00 00 -> no wr_en, done pulse on the edge after the second byte, err=0.
- Oversize: start; bytes 01 01 (N=257 > 256) -> ERR, err=1, no wr_en, cpu_hold=0. A subsequent start clears err.
- Checksum (LOADER_CHECKSUM_EN defined): 00 01 12 34 26 -> write 0x1234 to adr0, then done. Same stream with final byte 27 -> err=1, no done.
